// File: rtl/dsp_frame_gen.sv
// Radar frame generator: CPI/PRI timing pulses, sample gate and
// multi-lane test pattern stream for the DSP chain.
module dsp_frame_gen #(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 2,
   parameter int SMP_PER_PRI = 256,
   parameter int PRI_LEN     = 400,
   parameter int SMP_OFS     = 16,
   parameter int PRI_PER_CPI = 32,
   parameter int CPI_GAP     = 100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_en,
   input  logic                     i_single,
   input  logic [1:0]               i_mode,
   input  logic [DATA_W-1:0]        i_const,
   output logic                     o_cpib,
   output logic                     o_cpie,
   output logic                     o_pri,
   output logic                     o_smp_gate,
   output logic                     o_tvalid,
   output logic [NUM_CH*DATA_W-1:0] o_tdata,
   output logic                     o_busy,
   output logic [15:0]              o_cpi_cnt
);

   localparam int CW = (PRI_LEN > 1) ? $clog2(PRI_LEN) : 1;
   localparam int PW = (PRI_PER_CPI > 1) ? $clog2(PRI_PER_CPI) : 1;
   localparam int GW = (CPI_GAP > 1) ? $clog2(CPI_GAP) : 1;

   localparam logic [CW-1:0] OFS_C   = CW'(SMP_OFS);
   localparam logic [CW-1:0] END_C   = CW'(SMP_OFS + SMP_PER_PRI - 1);
   localparam logic [CW-1:0] LAST_C  = CW'(PRI_LEN - 1);
   localparam logic [PW-1:0] PLAST_C = PW'(PRI_PER_CPI - 1);
   localparam logic [GW-1:0] GLAST_C = GW'(CPI_GAP - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       clk_cnt, clk_cnt_nx;
   logic [PW-1:0]       pri_idx, pri_idx_nx;
   logic [GW-1:0]       gap_cnt, gap_cnt_nx;
   logic [DATA_W-1:0]   n_idx, n_idx_nx;
   logic [1:0]          mode_r, mode_nx;
   logic [DATA_W-1:0]   const_r, const_nx;
   logic                single_flag, single_nx;
   logic                relaunch;
   logic                pri_last;
   logic                cpi_last;
   logic                gate;
   logic [NUM_CH*DATA_W-1:0] lane_data;

   assign pri_last = (clk_cnt == LAST_C);
   assign cpi_last = (state == RUN) && pri_last && (pri_idx == PLAST_C);
   assign gate     = (state == RUN) && (clk_cnt >= OFS_C) &&
                     (clk_cnt <= END_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         pri_idx     <= '0;
         gap_cnt     <= '0;
         n_idx       <= '0;
         mode_r      <= '0;
         const_r     <= '0;
         single_flag <= 1'b0;
      end else begin
         state       <= state_nx;
         clk_cnt     <= clk_cnt_nx;
         pri_idx     <= pri_idx_nx;
         gap_cnt     <= gap_cnt_nx;
         n_idx       <= n_idx_nx;
         mode_r      <= mode_nx;
         const_r     <= const_nx;
         single_flag <= single_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clk_cnt_nx = clk_cnt;
      pri_idx_nx = pri_idx;
      gap_cnt_nx = gap_cnt;
      n_idx_nx   = n_idx;
      mode_nx    = mode_r;
      const_nx   = const_r;
      single_nx  = single_flag;
      relaunch   = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_en || i_single) begin
               relaunch  = 1'b1;
               single_nx = !i_en;
            end
         end
         RUN: begin
            if (gate) n_idx_nx = n_idx + 1'b1;
            if (pri_last) begin
               clk_cnt_nx = '0;
               pri_idx_nx = pri_idx + 1'b1;
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
            if (cpi_last) begin
               if (CPI_GAP > 0) begin
                  state_nx   = GAP;
                  gap_cnt_nx = '0;
               end else if (i_en && !single_flag) begin
                  relaunch = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GLAST_C) begin
               if (i_en && !single_flag) relaunch = 1'b1;
               else state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // a new CPI restarts the timeline and snapshots the pattern setup
      if (relaunch) begin
         state_nx   = RUN;
         clk_cnt_nx = '0;
         pri_idx_nx = '0;
         n_idx_nx   = '0;
         mode_nx    = i_mode;
         const_nx   = i_const;
      end
   end

   always_comb begin
      lane_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         case (mode_r)
            2'd1:    lane_data[k*DATA_W +: DATA_W] = const_r + DATA_W'(k);
            2'd2:    lane_data[k*DATA_W +: DATA_W] =
                        {4'(k), n_idx[DATA_W-5:0]};
            default: lane_data[k*DATA_W +: DATA_W] = n_idx + DATA_W'(k);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_cpib     <= 1'b0;
         o_cpie     <= 1'b0;
         o_pri      <= 1'b0;
         o_smp_gate <= 1'b0;
         o_tvalid   <= 1'b0;
         o_tdata    <= '0;
         o_busy     <= 1'b0;
         o_cpi_cnt  <= '0;
      end else begin
         o_cpib     <= (state == RUN) && (clk_cnt == '0) && (pri_idx == '0);
         o_cpie     <= cpi_last;
         o_pri      <= (state == RUN) && (clk_cnt == '0);
         o_smp_gate <= gate;
         o_tvalid   <= gate;
         o_busy     <= (state != IDLE);
         if (gate) o_tdata <= lane_data;
         if (cpi_last) o_cpi_cnt <= o_cpi_cnt + 16'd1;
      end
   end

endmodule

// File: doc/dsp_frame_gen.md
# dsp_frame_gen

Parametrised radar frame generator that drives the DSP chain's CPI/PRI timing and sample stream: `o_cpib`, `o_cpie`, `o_pri`, `o_smp_gate`, `o_tvalid` and `o_tdata`. It generalises the fixed single-channel 16-bit tester in several ways: configurable data width, lane count, frame geometry and data pattern, plus one-shot and continuous run modes. It sits upstream of `dsp_top`, either in the simulation bench or as an on-chip self-test source.

## Interface
Parameters:
- DATA_W, 16, sample width per lane (≥8)
- NUM_CH, 2, parallel lanes (1–16)
- SMP_PER_PRI, 256, samples per PRI
- PRI_LEN, 400, clocks per PRI (≥ SMP_OFS+SMP_PER_PRI)
- SMP_OFS, 16, clocks from PRI start to first sample
- PRI_PER_CPI, 32, PRIs per CPI
- CPI_GAP, 100, idle clocks after each CPI (0 allowed)

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous assert, active-low
- i_en  in  1  continuous-run enable, level
- i_single  in  1  one-CPI start pulse
- i_mode  in  2  pattern: 0 ramp, 1 constant, 2 lane-tag, 3 reserved (treated as 0)
- i_const  in  DATA_W  constant-mode base value
- o_cpib  out  1  1-cycle pulse, first cycle of a CPI
- o_cpie  out  1  1-cycle pulse, last cycle of a CPI
- o_pri  out  1  1-cycle pulse, first cycle of each PRI
- o_smp_gate  out  1  high across the sample window
- o_tvalid  out  1  sample valid
- o_tdata  out  NUM_CH*DATA_W  lane k in bits [k*DATA_W +: DATA_W]
- o_busy  out  1  high from CPI start through end of gap
- o_cpi_cnt  out  16  completed-CPI count

## Operation
- FSM states: IDLE, RUN, GAP. Counters: clk_cnt (0..PRI_LEN-1), pri_idx (0..PRI_PER_CPI-1), gap_cnt, smp_idx (0..SMP_PER_PRI-1).
- IDLE → RUN when `i_en`=1 or `i_single`=1. Clear the counters. Latch `i_mode` and `i_const` into per-CPI registers. Set a single_flag when `i_en`=0.
- In RUN, clk_cnt increments every cycle. At PRI_LEN-1 it wraps to 0 and pri_idx increments.
- At the last cycle of the last PRI: go to GAP if CPI_GAP>0; otherwise apply the GAP-exit rule immediately.
- GAP exits after CPI_GAP cycles:
  - To RUN (new CPI, re-latch mode/const) if `i_en`=1 and single_flag=0.
  - Otherwise to IDLE.
- Deasserting `i_en` mid-CPI never truncates the CPI. The current CPI and its gap always complete.
- `i_single` outside IDLE is ignored. `i_single` together with `i_en`=1 in IDLE counts as a continuous start.
- Gate: `o_smp_gate`=`o_tvalid`=1 iff RUN and SMP_OFS ≤ clk_cnt < SMP_OFS+SMP_PER_PRI.
- Data index n = pri_idx*SMP_PER_PRI + smp_idx. It restarts at 0 each CPI.
- Lane k data, all arithmetic mod 2^DATA_W:
  - Mode 0: n+k
  - Mode 1: const+k
  - Mode 2: {k[3:0], n[DATA_W-5:0]}
- `o_tdata` holds its last value when `o_tvalid`=0 and resets to 0.
- `o_cpi_cnt` increments by 1 with each `o_cpie` and wraps from 0xFFFF to 0.

## Timing
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- Start: if `i_en`/`i_single` is sampled high in IDLE at edge E, then at edge E+1 the outputs show cycle 0, with `o_cpib`=`o_pri`=`o_busy`=1.
- Relative to cycle 0:
  - `o_pri` at c*PRI_LEN.
  - `o_tvalid` in [c*PRI_LEN+SMP_OFS, c*PRI_LEN+SMP_OFS+SMP_PER_PRI-1].
  - `o_cpie` at PRI_PER_CPI*PRI_LEN-1.
  - `o_busy` falls after cycle PRI_PER_CPI*PRI_LEN+CPI_GAP-1.
  - Next `o_cpib`, continuous mode, at PRI_PER_CPI*PRI_LEN+CPI_GAP.
- Back-to-back: with CPI_GAP=0, `o_cpie` and the next `o_cpib` fall on adjacent cycles.
- PRI_PER_CPI=1: `o_cpib` and `o_pri` coincide. `o_cpie` at PRI_LEN-1.
- `rst_n` low mid-CPI: all outputs drop to 0 asynchronously, `o_cpi_cnt`=0 included. After release the block waits in IDLE for a new start.
- Changes to `i_mode`/`i_const` mid-CPI take effect only at the next `o_cpib`.

## Test plan
Bench params: DATA_W=16, NUM_CH=2, SMP_PER_PRI=8, PRI_LEN=16, SMP_OFS=4, PRI_PER_CPI=3, CPI_GAP=5.
- One-shot ramp: `i_single` pulse, `i_en`=0, mode 0 → `o_cpib` at cycle 0; `o_pri` at 0/16/32; `o_tvalid` in 4–11, 20–27, 36–43 (24 beats); lane0 0..23, lane1 1..24; `o_cpie` at 47; `o_busy` low from 53; `o_cpi_cnt`=1; no further `o_cpib`.
- Continuous: `i_en` held high → `o_cpib` at 0, 53, 106; ramp restarts at 0 each CPI; `o_cpi_cnt` counts 1, 2, 3.
- Enable drop: `i_en`=0 at cycle 20 → CPI finishes with `o_cpie` at 47, gap ends at 52, then IDLE and no `o_cpib` at 53.
- Constant mode: mode 1, `i_const`=0x1234, change to 0xFFFF at cycle 10 → lane0 0x1234 and lane1 0x1235 for the whole CPI; the next CPI gives lane0 0xFFFF and lane1 0x0000 (wrap).
- Lane-tag mode: mode 2 → lane0 0x0000..0x0017, lane1 0x1000..0x1017.
- Reset mid-CPI: `rst_n` low at cycle 25 → all outputs 0 immediately; after release they stay 0, FSM in IDLE, `o_cpi_cnt`=0 until the next start.
